// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle for pipe_stage_buf: upstream entry in, head entry out.
// master = producer/consumer side (testbench or parent), slave = the buffer stage.
interface pipe_stage_buf_if #(
    parameter int unsigned PC_BITS   = 32,
    parameter int unsigned IR_BITS   = 32,
    parameter int unsigned DATA_BITS = 64
);
    logic                 in_valid;
    logic                 in_ready;
    logic [PC_BITS-1:0]   PC_in;
    logic [IR_BITS-1:0]   IR_in;
    logic [DATA_BITS-1:0] data_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [PC_BITS-1:0]   PC_out;
    logic [IR_BITS-1:0]   IR_out;
    logic [DATA_BITS-1:0] data_out;

    modport master (
        output in_valid, PC_in, IR_in, data_in, out_ready,
        input  in_ready, out_valid, PC_out, IR_out, data_out
    );

    modport slave (
        input  in_valid, PC_in, IR_in, data_in, out_ready,
        output in_ready, out_valid, PC_out, IR_out, data_out
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Two-entry (main + skid) pipeline stage buffer, one-cycle latency, registered in_ready.
// Optional stall/bubble counters when PIPE_STAGE_BUF_PERF_CNT_EN is defined.
module pipe_stage_buf #(
    parameter int unsigned PC_BITS   = 32,
    parameter int unsigned IR_BITS   = 32,
    parameter int unsigned DATA_BITS = 64
) (
    input  logic               clk,
    input  logic               zero,
    input  logic               flush,
    pipe_stage_buf_if.slave    bus,
    output logic [1:0]         occupancy
`ifdef PIPE_STAGE_BUF_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [PC_BITS-1:0]   main_pc,   skid_pc;
    logic [IR_BITS-1:0]   main_ir,   skid_ir;
    logic [DATA_BITS-1:0] main_data, skid_data;
    logic                 accept;
    logic                 issue;

    assign accept = bus.in_valid & in_ready_q;
    assign issue  = out_valid_q & bus.out_ready;

    always_ff @(posedge clk) begin
        if (zero || flush) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_pc     <= '0;
            main_ir     <= '0;
            main_data   <= '0;
            skid_pc     <= '0;
            skid_ir     <= '0;
            skid_data   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                        main_pc     <= bus.PC_in;
                        main_ir     <= bus.IR_in;
                        main_data   <= bus.data_in;
                    end
                end
                ONE: begin
                    if (accept && !issue) begin
                        state      <= FULL;
                        in_ready_q <= 1'b0;
                        skid_pc    <= bus.PC_in;
                        skid_ir    <= bus.IR_in;
                        skid_data  <= bus.data_in;
                    end else if (accept && issue) begin
                        main_pc   <= bus.PC_in;
                        main_ir   <= bus.IR_in;
                        main_data <= bus.data_in;
                    end else if (issue) begin
                        // Departing entry is zeroed so an empty stage presents a nop bubble.
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                        main_pc     <= '0;
                        main_ir     <= '0;
                        main_data   <= '0;
                    end
                end
                FULL: begin
                    if (issue) begin
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                        main_pc    <= skid_pc;
                        main_ir    <= skid_ir;
                        main_data  <= skid_data;
                        skid_pc    <= '0;
                        skid_ir    <= '0;
                        skid_data  <= '0;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    main_pc     <= '0;
                    main_ir     <= '0;
                    main_data   <= '0;
                    skid_pc     <= '0;
                    skid_ir     <= '0;
                    skid_data   <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.PC_out    = main_pc;
    assign bus.IR_out    = main_ir;
    assign bus.data_out  = main_data;
    assign occupancy     = state;

`ifdef PIPE_STAGE_BUF_PERF_CNT_EN
    // Counters ignore flush; only zero clears them, and both saturate.
    always_ff @(posedge clk) begin
        if (zero) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid_q && !bus.out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
            if (!out_valid_q && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf; define PIPE_STAGE_BUF_PERF_CNT_EN
// to also exercise the stall/bubble counters.
module tb_pipe_stage_buf;

    logic       clk = 1'b0;
    logic       zero;
    logic       flush;
    logic [1:0] occupancy;
`ifdef PIPE_STAGE_BUF_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
`endif

    int passed = 0;
    int total  = 0;

    pipe_stage_buf_if #(.PC_BITS(32), .IR_BITS(32), .DATA_BITS(64)) bus ();

    pipe_stage_buf #(.PC_BITS(32), .IR_BITS(32), .DATA_BITS(64)) dut (
        .clk       (clk),
        .zero      (zero),
        .flush     (flush),
        .bus       (bus.slave),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_BUF_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                         input logic [63:0] d);
        bus.in_valid = v;
        bus.PC_in    = pc;
        bus.IR_in    = ir;
        bus.data_in  = d;
    endtask

    task automatic test_reset();
        zero = 1'b1; flush = 1'b0; bus.out_ready = 1'b0;
        drive(1'b1, 32'h1234, 32'h99, 64'h55);
        step();
        total++; if (occupancy !== 2'd0) $display("FAIL reset_occ got=%0d exp=0", occupancy); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else passed++;
        total++; if ({bus.PC_out, bus.IR_out, bus.data_out} !== 128'd0)
            $display("FAIL reset_fields got=%h/%h/%h exp=0", bus.PC_out, bus.IR_out, bus.data_out); else passed++;
`ifdef PIPE_STAGE_BUF_PERF_CNT_EN
        total++; if ({stall_cnt, bubble_cnt} !== 64'd0)
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, bubble_cnt); else passed++;
`endif
        zero = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 64'h0);
        step();
    endtask

    task automatic test_streaming();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'h1000 + 32'(4*i), 32'(i), 64'(i) << 32);
            step();
            total++; if (bus.IR_out !== 32'(i) || bus.PC_out !== 32'h1000 + 32'(4*i) || bus.data_out !== (64'(i) << 32))
                $display("FAIL stream_out%0d got=%h/%h/%h", i, bus.PC_out, bus.IR_out, bus.data_out); else passed++;
            total++; if (occupancy !== 2'd1 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1)
                $display("FAIL stream_flags%0d got occ=%0d rdy=%b vld=%b exp 1/1/1", i, occupancy, bus.in_ready, bus.out_valid); else passed++;
        end
        drive(1'b0, 32'h0, 32'h0, 64'h0);
        step();
        total++; if (occupancy !== 2'd0) $display("FAIL stream_end_occ got=%0d exp=0", occupancy); else passed++;
    endtask

    task automatic test_drain();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hA0, 32'hA1, 64'hA2);
        step();
        total++; if (bus.out_valid !== 1'b1 || bus.IR_out !== 32'hA1)
            $display("FAIL drain_load got vld=%b ir=%h exp 1/a1", bus.out_valid, bus.IR_out); else passed++;
        drive(1'b0, 32'h0, 32'h0, 64'h0);
        bus.out_ready = 1'b1;
        step();
        total++; if (bus.out_valid !== 1'b0 || occupancy !== 2'd0)
            $display("FAIL drain_empty got vld=%b occ=%0d exp 0/0", bus.out_valid, occupancy); else passed++;
        total++; if ({bus.PC_out, bus.IR_out, bus.data_out} !== 128'd0)
            $display("FAIL drain_zero got=%h/%h/%h exp=0", bus.PC_out, bus.IR_out, bus.data_out); else passed++;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h110, 32'h11, 64'h1111);
        step();
        total++; if (occupancy !== 2'd1 || bus.IR_out !== 32'h11)
            $display("FAIL bp_first got occ=%0d ir=%h exp 1/11", occupancy, bus.IR_out); else passed++;
        drive(1'b1, 32'h220, 32'h22, 64'h2222);
        step();
        total++; if (occupancy !== 2'd2 || bus.in_ready !== 1'b0 || bus.IR_out !== 32'h11)
            $display("FAIL bp_full got occ=%0d rdy=%b ir=%h exp 2/0/11", occupancy, bus.in_ready, bus.IR_out); else passed++;
        drive(1'b1, 32'h330, 32'h33, 64'h3333);
        step();
        total++; if (occupancy !== 2'd2 || bus.in_ready !== 1'b0 || bus.PC_out !== 32'h110 ||
                     bus.IR_out !== 32'h11 || bus.data_out !== 64'h1111)
            $display("FAIL bp_hold got occ=%0d rdy=%b %h/%h/%h exp 2/0 110/11/1111",
                     occupancy, bus.in_ready, bus.PC_out, bus.IR_out, bus.data_out); else passed++;
        bus.out_ready = 1'b1;
        step();
        total++; if (bus.IR_out !== 32'h22 || occupancy !== 2'd1 || bus.in_ready !== 1'b1)
            $display("FAIL bp_second got ir=%h occ=%0d rdy=%b exp 22/1/1", bus.IR_out, occupancy, bus.in_ready); else passed++;
        step();
        total++; if (bus.IR_out !== 32'h33 || bus.PC_out !== 32'h330 || occupancy !== 2'd1)
            $display("FAIL bp_third got ir=%h pc=%h occ=%0d exp 33/330/1", bus.IR_out, bus.PC_out, occupancy); else passed++;
        drive(1'b0, 32'h0, 32'h0, 64'h0);
        step();
        total++; if (bus.out_valid !== 1'b0 || bus.IR_out !== 32'h0)
            $display("FAIL bp_drain got vld=%b ir=%h exp 0/0", bus.out_valid, bus.IR_out); else passed++;
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h500, 32'h55, 64'h5);
        step();
        drive(1'b1, 32'h600, 32'h66, 64'h6);
        step();
        total++; if (occupancy !== 2'd2) $display("FAIL flush_prefill got occ=%0d exp=2", occupancy); else passed++;
        drive(1'b1, 32'h700, 32'h44, 64'h7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (occupancy !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.IR_out !== 32'h0)
            $display("FAIL flush_empty got occ=%0d vld=%b rdy=%b ir=%h exp 0/0/1/0",
                     occupancy, bus.out_valid, bus.in_ready, bus.IR_out); else passed++;
        drive(1'b0, 32'h0, 32'h0, 64'h0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (bus.out_valid !== 1'b0 || bus.IR_out !== 32'h0)
                $display("FAIL flush_no44_%0d got vld=%b ir=%h exp 0/0", i, bus.out_valid, bus.IR_out); else passed++;
        end
    endtask

    task automatic test_zero_flush();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h800, 32'h88, 64'h8);
        step();
        drive(1'b1, 32'h900, 32'h99, 64'h9);
        zero = 1'b1; flush = 1'b1;
        step();
        total++; if (occupancy !== 2'd0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
                     {bus.PC_out, bus.IR_out, bus.data_out} !== 128'd0)
            $display("FAIL zf_reset got occ=%0d rdy=%b vld=%b %h/%h/%h exp 0/1/0 zero",
                     occupancy, bus.in_ready, bus.out_valid, bus.PC_out, bus.IR_out, bus.data_out); else passed++;
        zero = 1'b0; flush = 1'b0;
        drive(1'b1, 32'hBFC00000, 32'h0, 64'h0);
        step();
        total++; if (bus.PC_out !== 32'hBFC00000 || bus.out_valid !== 1'b1)
            $display("FAIL zf_boot got pc=%h vld=%b exp bfc00000/1", bus.PC_out, bus.out_valid); else passed++;
        drive(1'b0, 32'h0, 32'h0, 64'h0);
        bus.out_ready = 1'b1;
        step();
    endtask

`ifdef PIPE_STAGE_BUF_PERF_CNT_EN
    task automatic test_perf_cnt();
        logic [31:0] s0;
        logic [31:0] b0;
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hC0, 32'hC1, 64'hC2);
        step();
        drive(1'b0, 32'h0, 32'h0, 64'h0);
        s0 = stall_cnt;
        for (int i = 0; i < 5; i++) step();
        total++; if (stall_cnt !== s0 + 32'd5) $display("FAIL perf_stall got=%0d exp=%0d", stall_cnt, s0 + 32'd5); else passed++;
        b0 = bubble_cnt;
        flush = 1'b1; bus.out_ready = 1'b1;
        step();
        flush = 1'b0;
        total++; if (stall_cnt !== s0 + 32'd5 || bubble_cnt !== b0)
            $display("FAIL perf_flush got=%0d/%0d exp=%0d/%0d", stall_cnt, bubble_cnt, s0 + 32'd5, b0); else passed++;
        step();
        total++; if (bubble_cnt !== b0 + 32'd1 || stall_cnt !== s0 + 32'd5)
            $display("FAIL perf_bubble got=%0d/%0d exp=%0d/%0d", stall_cnt, bubble_cnt, s0 + 32'd5, b0 + 32'd1); else passed++;
    endtask
`endif

    initial begin
        zero = 1'b1; flush = 1'b0; bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 64'h0);
        #1;
        test_reset();
        test_streaming();
        test_drain();
        test_backpressure();
        test_flush();
        test_zero_flush();
`ifdef PIPE_STAGE_BUF_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter PC_BITS, default 32, width of the PC field.
REQ-002 Parameter IR_BITS, default 32, width of the instruction field.
REQ-003 Parameter DATA_BITS, default 64, width of the opaque payload (control bits, ALU/mem/HI/LO data packed by the parent).
REQ-004 clk  input  1  single clock, all state updates on posedge.
REQ-005 zero  input  1  reset, synchronous and active-high; one clock, synchronous active-high reset.
REQ-006 flush  input  1  synchronous kill of all buffered entries.
REQ-007 in_valid  input  1  upstream entry present.
REQ-008 in_ready  output  1  stage can accept an entry this cycle.
REQ-009 PC_in / IR_in / data_in  input  PC_BITS / IR_BITS / DATA_BITS  upstream entry fields.
REQ-010 out_valid  output  1  downstream entry present.
REQ-011 out_ready  input  1  downstream consumes the entry this cycle.
REQ-012 PC_out / IR_out / data_out  output  PC_BITS / IR_BITS / DATA_BITS  head entry fields.
REQ-013 occupancy  output  2  number of buffered entries, 0..2.

Function
REQ-014 The block SHALL hold a two-entry buffer (main + skid) with states EMPTY, ONE, FULL; accept = in_valid & in_ready; issue = out_valid & out_ready.
REQ-015 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, driven from registered state only (no combinational path from out_ready).
REQ-016 out_valid SHALL be 1 in ONE and FULL; PC_out/IR_out/data_out SHALL come from the main register only.
REQ-017 EMPTY: accept -> ONE, main <- input; otherwise stay.
REQ-018 ONE: accept & !issue -> FULL, skid <- input; accept & issue -> ONE, main <- input; !accept & issue -> EMPTY; neither -> stay, main held.
REQ-019 FULL: issue -> ONE, main <- skid, skid cleared; !issue -> stay, both held.
REQ-020 Latency SHALL be one cycle: an entry accepted at edge N is on the outputs after edge N, in acceptance order, none dropped or duplicated.
REQ-021 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-022 Any entry leaving the buffer without replacement SHALL zero its register; in EMPTY PC_out, IR_out, data_out SHALL be 0 (IR 0 = nop bubble).
REQ-023 flush=1 SHALL force EMPTY and zero main and skid at the next edge, regardless of in_valid/out_ready; an entry presented that cycle is discarded.
REQ-024 Priority SHALL be zero > flush > normal transfer.
REQ-025 occupancy SHALL equal 0/1/2 in EMPTY/ONE/FULL.

Reset
REQ-026 zero=1 at a posedge SHALL set state EMPTY, occupancy 0, in_ready 1, out_valid 0, PC_out/IR_out/data_out 0, skid 0, counters 0.
REQ-027 zero asserted mid-transfer SHALL discard all buffered entries; first accept possible the cycle after zero deasserts.

Configuration
REQ-028 Macro PIPE_STAGE_BUF_PERF_CNT_EN, when defined, SHALL add outputs stall_cnt (32) and bubble_cnt (32).
REQ-029 With the macro, stall_cnt SHALL increment each cycle out_valid & !out_ready; bubble_cnt SHALL increment each cycle out_valid=0; both saturate at 32'hFFFFFFFF, cleared by zero only, unaffected by flush.
REQ-030 Without the macro the ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-031 Streaming: in_valid=1 and out_ready=1 continuously, IR_in=1,2,3,4 -> IR_out 1,2,3,4 on consecutive cycles, one cycle after each accept, occupancy stays 1, in_ready stays 1.
REQ-032 Backpressure: out_ready=0, feed IR 0x11, 0x22, 0x33 -> 0x11, 0x22 accepted, occupancy 2, in_ready 0, 0x33 held upstream; release out_ready -> outputs 0x11, 0x22, 0x33 in order.
REQ-033 Flush in FULL with in_valid=1 (IR 0x44) -> next cycle occupancy 0, out_valid 0, IR_out 0, in_ready 1, 0x44 never appears.
REQ-034 zero and flush both high during transfer -> reset values per REQ-026; deassert zero, send PC 0xBFC00000 -> appears on PC_out one cycle later.
REQ-035 Drain: one entry, in_valid=0, out_ready=1 -> out_valid 0 next cycle and PC_out/IR_out/data_out all 0.
REQ-036 With PIPE_STAGE_BUF_PERF_CNT_EN: 5 cycles out_valid=1, out_ready=0, then flush -> stall_cnt=5, bubble_cnt increments from the cycle after flush, stall_cnt unchanged by flush.
